// File: rtl/cpu_pkg.sv
// Shared pipeline constants: the hardwired-zero register address and the
// writeback source encoding, also consumed by the hazard/forwarding unit.
package cpu_pkg;

  localparam int unsigned REG_ZERO = 0;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_JAL = 2'd2;

  // JAL link value outranks a load, which outranks the ALU result.
  function automatic logic [1:0] wb_sel_encode(input logic is_jal,
                                               input logic mem_to_reg);
    if (is_jal)          return WB_SEL_JAL;
    else if (mem_to_reg) return WB_SEL_MEM;
    else                 return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/wb_data_sel.sv
// Writeback source mux: picks the value the WB stage commits to the register file.
module wb_data_sel
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_is_jal,
  input  logic                  i_mem_to_reg,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_jal_link_value,
  output logic [DATA_WIDTH-1:0] o_wr_data
);

  logic [1:0] w_sel;

  assign w_sel = wb_sel_encode(i_is_jal, i_mem_to_reg);

  always_comb begin
    o_wr_data = i_alu_result;
    case (w_sel)
      WB_SEL_JAL: o_wr_data = i_jal_link_value;
      WB_SEL_MEM: o_wr_data = i_read_data;
      default:    o_wr_data = i_alu_result;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage fused with the architectural register file: commit, two
// bypassed combinational read ports, EX forwarding export and a commit counter.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_reg_write,
  input  logic                     wb_mem_to_reg,
  input  logic                     wb_is_jal,
  input  logic [DATA_WIDTH-1:0]    wb_read_data,
  input  logic [DATA_WIDTH-1:0]    wb_alu_result,
  input  logic [DATA_WIDTH-1:0]    wb_jal_link_value,
  input  logic [REGADDR_WIDTH-1:0] wb_rd,
  input  logic [REGADDR_WIDTH-1:0] rs1_addr,
  input  logic [REGADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0]    rs1_data,
  output logic [DATA_WIDTH-1:0]    rs2_data,
  output logic                     wb_fwd_en,
  output logic [REGADDR_WIDTH-1:0] wb_fwd_rd,
  output logic [DATA_WIDTH-1:0]    wb_fwd_data,
  output logic [CNT_WIDTH-1:0]     wr_count
);

  localparam int NUM_REGS = 2 ** REGADDR_WIDTH;
  localparam logic [REGADDR_WIDTH-1:0] ZERO_ADDR = REGADDR_WIDTH'(REG_ZERO);

  // r0 has no storage; index range starts at 1.
  logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];
  logic [CNT_WIDTH-1:0]  r_wr_count;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_commit;

  wb_data_sel #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wb_data_sel (
    .i_is_jal        (wb_is_jal),
    .i_mem_to_reg    (wb_mem_to_reg),
    .i_read_data     (wb_read_data),
    .i_alu_result    (wb_alu_result),
    .i_jal_link_value(wb_jal_link_value),
    .o_wr_data       (w_wr_data)
  );

  assign w_commit = wb_reg_write & (wb_rd != ZERO_ADDR) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_regs[wb_rd] <= w_wr_data;
      r_wr_count    <= r_wr_count + 1'b1;
    end
  end

  // Same-cycle bypass lets decode see the value being committed this cycle.
  always_comb begin
    rs1_data = '0;
    if (!reset && rs1_addr != ZERO_ADDR) begin
      if (w_commit && rs1_addr == wb_rd) rs1_data = w_wr_data;
      else                               rs1_data = r_regs[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (!reset && rs2_addr != ZERO_ADDR) begin
      if (w_commit && rs2_addr == wb_rd) rs2_data = w_wr_data;
      else                               rs2_data = r_regs[rs2_addr];
    end
  end

  assign wb_fwd_en   = w_commit;
  assign wb_fwd_rd   = reset ? '0 : wb_rd;
  assign wb_fwd_data = reset ? '0 : w_wr_data;
  assign wr_count    = r_wr_count;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the writeback stage fused with the architectural register file.
- Selects the writeback value from the registered WB-stage signals and commits it to the register file.
- Serves two combinational decode-stage read ports with same-cycle write-to-read bypass.
- Exports the committed write (enable/addr/data) for EX-stage forwarding, plus a write-commit counter for debug/perf.

Parameters:
- DATA_WIDTH, 16, width of registers and all data buses
- REGADDR_WIDTH, 4, register address width; register count NUM_REGS = 2**REGADDR_WIDTH (derived localparam, not overridable)
- CNT_WIDTH, 16, width of the write-commit counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wb_reg_write  in  1  writeback enable from MEM/WB
- wb_mem_to_reg  in  1  select memory read data
- wb_is_jal  in  1  select JAL link value (highest priority)
- wb_read_data  in  DATA_WIDTH  load data
- wb_alu_result  in  DATA_WIDTH  ALU result
- wb_jal_link_value  in  DATA_WIDTH  return address
- wb_rd  in  REGADDR_WIDTH  destination register
- rs1_addr  in  REGADDR_WIDTH  read port 1 address
- rs2_addr  in  REGADDR_WIDTH  read port 2 address
- rs1_data  out  DATA_WIDTH  read port 1 data (combinational)
- rs2_data  out  DATA_WIDTH  read port 2 data (combinational)
- wb_fwd_en  out  1  a real write commits this cycle
- wb_fwd_rd  out  REGADDR_WIDTH  address of committing write
- wb_fwd_data  out  DATA_WIDTH  value being committed
- wr_count  out  CNT_WIDTH  registered count of committed writes

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Write-data select (combinational):
  - wb_is_jal=1 -> wb_jal_link_value
  - else wb_mem_to_reg=1 -> wb_read_data
  - else -> wb_alu_result
- Commit condition: commit = wb_reg_write & (wb_rd != 0) & ~reset.
- When commit is true, regs[wb_rd] <= selected data at the rising edge.
- Register 0 is hardwired to zero: never written, always reads 0, no storage required.
- wb_fwd_en = commit; wb_fwd_rd = wb_rd; wb_fwd_data = selected data. All combinational, zero latency.
- Read ports (combinational), for each port:
  - addr==0 -> 0
  - else if commit & (addr==wb_rd) -> selected write data (bypass, same cycle)
  - else -> regs[addr]
- Both ports may hit the same address and/or the bypass simultaneously; each is resolved independently.
- Write latency: value visible through regs on the cycle after the edge, and via bypass in the cycle of the write itself.
- wr_count:
  - increments by 1 at each edge where commit=1
  - wraps from 2**CNT_WIDTH-1 to 0
  - writes to r0 and bubbles (wb_reg_write=0) do not count
- Reset, synchronous: at a rising edge with reset=1:
  - all NUM_REGS registers cleared to 0
  - wr_count cleared to 0
  - any concurrent write is discarded (reset wins)
- While reset is high:
  - rs1_data = rs2_data = 0
  - wb_fwd_en = 0; wb_fwd_rd and wb_fwd_data are don't-care but driven to 0
- Reset asserted mid-stream: the in-flight WB write is dropped. The first post-reset write commits normally on the first edge with reset=0.
- X-safety: with wb_reg_write=0, the select mux and rd have no architectural effect.

Decomposition:
- Shared package (cpu_pkg): REG_ZERO address constant and writeback select encoding constants (WB_SEL_ALU, WB_SEL_MEM, WB_SEL_JAL). Both are reused by the hazard/forwarding unit.
- One sub-module, wb_data_sel: the combinational 3:1 priority mux producing the write data.
- Storage, bypass and counter stay in wb_regfile.

Test Plan:
- Reset: hold reset 2 cycles with wb_reg_write=1, wb_rd=3, alu=0x1234 -> regs all 0, wr_count=0, rs1_addr=3 reads 0 after release.
- Mux priority: rd=5, alu=0x00AA, mem=0x00BB, link=0x00CC:
  - is_jal=1,mem_to_reg=1 -> r5=0x00CC
  - is_jal=0,mem_to_reg=1 -> 0x00BB
  - both 0 -> 0x00AA
  - wr_count=3
- r0 protection: write rd=0 data 0xFFFF -> rs1_addr=0 reads 0, wb_fwd_en=0, wr_count unchanged.
- Bypass: r7=0x1111 stored; in the cycle writing r7=0x2222, rs1_addr=rs2_addr=7 -> both read 0x2222 combinationally; next cycle regs read 0x2222.
- Bubble: wb_reg_write=0, rd=4, alu=0x5555 -> r4 unchanged, wb_fwd_en=0, no count.
- Counter wrap and reset mid-stream:
  - with CNT_WIDTH=4, 17 commits -> wr_count=1
  - then reset during a write of r2=0x0F0F -> r2=0, wr_count=0
